// File: rtl/uart_rx_if.sv
// Byte-side handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised RXD, mid-cell sampling, valid/ready byte output, sticky errors.
// Define UART_RX_PARITY_EN to receive an even-parity bit between data and stop.
module uart_rx #(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned BAUD        = 115_200
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      RXD,
  uart_rx_if.master rx_if,
  input  logic      err_clr,
  output logic      rx_overrun,
  output logic      rx_frame_err,
  output logic      rx_parity_err
);

  localparam int unsigned DIV  = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY  = 3'd5
`endif
  } state_e;

  state_e        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          overrun_q;
  logic          frame_q;

  logic          rxd_s;
  logic [7:0]    shift_d;
  logic          bit_tick_s;
  logic          stop_ok_s;
  logic          frame_bad_s;
  logic          deliver_s;
  logic          overrun_s;
  logic          load_s;

`ifdef UART_RX_PARITY_EN
  logic          par_pend_q;
  logic          par_err_q;
  logic          par_bad_s;
`endif

  assign rxd_s = sync_q[1];

  // Two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], RXD};
    end
  end

  // Stop-bit outcome and the byte-delivery decision for this cycle
  always_comb begin
    shift_d     = {rxd_s, shift_q[7:1]};
    bit_tick_s  = (cnt_q == DIV_LAST);
    stop_ok_s   = (state_q == S_STOP) && bit_tick_s && rxd_s;
    frame_bad_s = (state_q == S_STOP) && bit_tick_s && !rxd_s;
`ifdef UART_RX_PARITY_EN
    deliver_s   = stop_ok_s && !par_pend_q;
    par_bad_s   = stop_ok_s && par_pend_q;
`else
    deliver_s   = stop_ok_s;
`endif
    // A completed byte is lost only if the held one is neither consumed nor replaced
    overrun_s   = deliver_s && valid_q && !rx_if.rx_ready;
    load_s      = deliver_s && !overrun_s;
  end

  // Receive FSM, output byte register and sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      frame_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_pend_q <= 1'b0;
      par_err_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_q + CNT_ONE;
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_DATA;
              bit_q   <= 3'd0;
            end
          end
        end
        S_DATA: begin
          if (bit_tick_s) begin
            cnt_q   <= '0;
            shift_q <= shift_d;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick_s) begin
            cnt_q      <= '0;
            par_pend_q <= rxd_s ^ (^shift_q);
            state_q    <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_tick_s) begin
            cnt_q   <= '0;
            state_q <= rxd_s ? S_IDLE : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: begin
          if (rxd_s) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase

      if (load_s) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end

      // A new error in the clearing cycle wins over err_clr
      overrun_q <= (overrun_q && !err_clr) || overrun_s;
      frame_q   <= (frame_q && !err_clr) || frame_bad_s;
`ifdef UART_RX_PARITY_EN
      par_err_q <= (par_err_q && !err_clr) || par_bad_s;
`endif
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_overrun     = overrun_q;
  assign rx_frame_err   = frame_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err  = par_err_q;
`else
  assign rx_parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model (latency formula + handshake rules) compared every cycle.
module tb_uart_rx;

  localparam int CLK_HZ = 25_000_000;
  localparam int BAUD_R = 115_200;
  localparam int DIV    = (CLK_HZ + BAUD_R / 2) / BAUD_R;
  localparam int HALF   = DIV / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR    = 1;
  localparam int LAT_LIT = 2281;
`else
  localparam int NPAR    = 0;
  localparam int LAT_LIT = 2064;
`endif
  // Edges from the first low RXD sample until the outputs change for that frame
  localparam int LAT    = 2 + HALF + (9 + NPAR) * DIV + 1;

  localparam int K_BYTE = 0;
  localparam int K_FE   = 1;
  localparam int K_PE   = 2;

  logic clk;
  logic reset;
  logic rxd;
  logic rx_ready;
  logic err_clr;
  logic rx_overrun;
  logic rx_frame_err;
  logic rx_parity_err;

  uart_rx_if bus ();
  assign bus.rx_ready = rx_ready;

  uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R)) dut (
    .clk          (clk),
    .reset        (reset),
    .RXD          (rxd),
    .rx_if        (bus),
    .err_clr      (err_clr),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_rst = -1;
  int         rise_cyc = 0;
  int         n_rise  = 0;
  logic       prev_valid = 1'b0;
  bit         rand_en = 1'b0;

  int         ev_kind[int];
  logic [7:0] ev_data[int];
  int         ev_fall[int];

  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  logic       m_ovr   = 1'b0;
  logic       m_fe    = 1'b0;
  logic       m_pe    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit dlv;
    bit n_ovr;
    bit n_fe;
    bit n_pe;
    dlv = 0; n_ovr = 0; n_fe = 0; n_pe = 0;
    if (reset) begin
      m_valid = 1'b0; m_data = 8'h00; m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
      last_rst = cyc;
    end else begin
      if (ev_kind.exists(cyc) && ev_fall[cyc] > last_rst) begin
        if (ev_kind[cyc] == K_BYTE) dlv = 1;
        else if (ev_kind[cyc] == K_FE) n_fe = 1;
        else n_pe = 1;
      end
      if (dlv) begin
        if (!m_valid || rx_ready) begin
          m_data  = ev_data[cyc];
          m_valid = 1'b1;
        end else begin
          n_ovr = 1;
        end
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
      m_ovr = (m_ovr && !err_clr) || n_ovr;
      m_fe  = (m_fe && !err_clr) || n_fe;
      m_pe  = (m_pe && !err_clr) || n_pe;
    end
  endtask

  task automatic compare_cycle();
    chk("rx_valid", {31'd0, bus.rx_valid}, {31'd0, m_valid});
    chk("rx_data", {24'd0, bus.rx_data}, {24'd0, m_data});
    chk("rx_overrun", {31'd0, rx_overrun}, {31'd0, m_ovr});
    chk("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, m_fe});
    chk("rx_parity_err", {31'd0, rx_parity_err}, {31'd0, m_pe});
    if (bus.rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cyc = cyc;
      n_rise++;
    end
    prev_valid = bus.rx_valid;
  endtask

  // Called at a negedge (or time 0); advances n full clocks, modelling and checking each one
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      cyc++;
      model_step();
      @(negedge clk);
      compare_cycle();
      if (rand_en) begin
        rx_ready = ($urandom_range(0, 1) == 1);
        err_clr  = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_flip);
    int key;
    key = cyc + LAT;
    if (!stop_b) ev_kind[key] = K_FE;
    else if (NPAR == 1 && par_flip) ev_kind[key] = K_PE;
    else ev_kind[key] = K_BYTE;
    ev_data[key] = d;
    ev_fall[key] = cyc;
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      tick(DIV);
    end
    if (NPAR == 1) begin
      rxd = (^d) ^ par_flip;
      tick(DIV);
    end
    rxd = stop_b;
    tick(DIV);
    rxd = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
  endtask

  initial begin
    int         fall_c;
    int         n0;
    int         gap;
    logic [7:0] rd;
    bit         sb;
    bit         pf;

    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
    tick(3);
    chk("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("reset_data", {24'd0, bus.rx_data}, 32'd0);
    chk("reset_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);
    reset = 1'b0;
    tick(4);

    // 1: latency and single handshake
    fall_c = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(DIV);
    chk("t1_latency", rise_cyc - fall_c, LAT_LIT);
    chk("t1_data", {24'd0, bus.rx_data}, 32'h0000_00A5);
    chk("t1_valid", {31'd0, bus.rx_valid}, 32'd1);
    consume();
    chk("t1_valid_drop", {31'd0, bus.rx_valid}, 32'd0);

    // 2: glitch rejected
    rxd = 1'b0;
    tick(50);
    rxd = 1'b1;
    tick(2 * DIV);
    chk("t2_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("t2_flags", {29'd0, rx_overrun, rx_frame_err, rx_parity_err}, 32'd0);

    // 3: framing error, clear, recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(2 * DIV);
    chk("t3_frame_err", {31'd0, rx_frame_err}, 32'd1);
    chk("t3_no_valid", {31'd0, bus.rx_valid}, 32'd0);
    clear_errs();
    chk("t3_frame_clr", {31'd0, rx_frame_err}, 32'd0);
    send_frame(8'h55, 1'b1, 1'b0);
    tick(DIV);
    chk("t3_data", {24'd0, bus.rx_data}, 32'h0000_0055);
    consume();

    // 4: back-to-back with and without a ready consumer
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2 * DIV);
    chk("t4_data", {24'd0, bus.rx_data}, 32'h0000_0011);
    chk("t4_overrun", {31'd0, rx_overrun}, 32'd1);
    consume();
    clear_errs();
    n0 = n_rise;
    rx_ready = 1'b1;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2 * DIV);
    rx_ready = 1'b0;
    chk("t4_two_bytes", n_rise - n0, 32'd2);
    chk("t4_no_overrun", {31'd0, rx_overrun}, 32'd0);

    // 5: reset four bit-times into 0x7E while a byte is held
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(DIV);
    rxd = 1'b0; tick(DIV);
    rxd = 1'b0; tick(DIV);
    rxd = 1'b1; tick(DIV);
    rxd = 1'b1; tick(DIV);
    reset = 1'b1;
    rxd = 1'b1;
    tick(1);
    chk("t5_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("t5_data", {24'd0, bus.rx_data}, 32'd0);
    reset = 1'b0;
    tick(3);
    send_frame(8'h81, 1'b1, 1'b0);
    tick(DIV);
    chk("t5_data_after", {24'd0, bus.rx_data}, 32'h0000_0081);
    consume();

`ifdef UART_RX_PARITY_EN
    // 6: even parity
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2 * DIV);
    chk("t6_parity_err", {31'd0, rx_parity_err}, 32'd1);
    chk("t6_no_valid", {31'd0, bus.rx_valid}, 32'd0);
    clear_errs();
    send_frame(8'h07, 1'b1, 1'b0);
    tick(DIV);
    chk("t6_data", {24'd0, bus.rx_data}, 32'h0000_0007);
    consume();
`endif

    // Randomised frames, gaps, consumer readiness and error clears
    rand_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      rd = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 5) != 0);
      pf = ($urandom_range(0, 3) == 0);
      send_frame(rd, sb, pf);
      gap = sb ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
      rxd = 1'b1;
      tick(gap * DIV);
    end
    rand_en = 1'b0;
    rx_ready = 1'b0;
    err_clr = 1'b0;
    tick(2 * DIV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
